// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector element serializer.
package vec_pkg;

    localparam int VEC_EW    = 8;
    localparam int VEC_NELEM = 4;

    typedef logic [VEC_EW-1:0] elem_t;

    // IDLE: no word held. SEND: word held, an element is on send_*.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Active element count, limited to the number of lanes in a word.
    function automatic int unsigned clamp_vl(input int unsigned vl, input int unsigned nelem);
        return (vl > nelem) ? nelem : vl;
    endfunction

endpackage

// File: rtl/vec_elem_serializer.sv
// Drains full-width vector words into a per-element val/rdy stream.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// val && rdy. send_val is never retracted once raised, and send_msg,
// send_idx and send_last hold stable while send_rdy is low. recv_rdy is
// combinational on send_rdy so a new word can be taken on the same edge
// as the last element of the current word, giving back-to-back words.
module vec_elem_serializer
    import vec_pkg::*;
#(
    parameter  int EW    = 8,
    parameter  int NELEM = 4,
    localparam int VLW   = $clog2(NELEM + 1),
    localparam int IW    = $clog2(NELEM)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NELEM*EW-1:0] recv_msg,
    input  logic [VLW-1:0]      recv_vl,
    input  logic                recv_val,
    output logic                recv_rdy,
    output logic [EW-1:0]       send_msg,
    output logic [IW-1:0]       send_idx,
    output logic                send_last,
    output logic                send_val,
    input  logic                send_rdy
);

    state_e              state_q, state_d;
    logic [NELEM*EW-1:0] word_q, word_d;
    logic [VLW-1:0]      vl_q, vl_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [VLW-1:0]      vl_eff;
    logic                last_w;
    logic                accept;

    // Zero-length words are consumed but never loaded.
    assign vl_eff   = VLW'(clamp_vl(32'(recv_vl), unsigned'(NELEM)));
    assign last_w   = (state_q == SEND) && ((VLW'(idx_q) + VLW'(1)) == vl_q);
    assign recv_rdy = (state_q == IDLE) || (send_rdy && last_w);
    assign accept   = recv_val && recv_rdy;

    assign send_val  = (state_q == SEND);
    assign send_idx  = idx_q;
    assign send_last = last_w;
    assign send_msg  = send_val ? word_q[idx_q*EW +: EW] : '0;

    // Next-state: load a word, step through its elements, or fall back to IDLE.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        vl_d    = vl_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept && (vl_eff != '0)) begin
                    state_d = SEND;
                    word_d  = recv_msg;
                    vl_d    = vl_eff;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (send_rdy) begin
                    if (!last_w) begin
                        idx_d = idx_q + IW'(1);
                    end else if (accept && (vl_eff != '0)) begin
                        word_d = recv_msg;
                        vl_d   = vl_eff;
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any partially sent word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            vl_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            vl_q    <= vl_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_vec_elem_serializer.sv
// Self-checking bench for vec_elem_serializer.
module tb_vec_elem_serializer;
    import vec_pkg::*;

    localparam int EW    = 8;
    localparam int NELEM = 4;
    localparam int VLW   = $clog2(NELEM + 1);
    localparam int IW    = $clog2(NELEM);
    localparam int W     = EW + IW + 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NELEM*EW-1:0] recv_msg = '0;
    logic [VLW-1:0]      recv_vl = '0;
    logic                recv_val = 1'b0;
    logic                recv_rdy;
    logic [EW-1:0]       send_msg;
    logic [IW-1:0]       send_idx;
    logic                send_last;
    logic                send_val;
    logic                send_rdy = 1'b0;

    logic [W-1:0] exp_q[$];
    int           beat_cyc[$];
    int           checks = 0;
    int           errors = 0;
    int           beats = 0;
    int           cyc = 0;
    int           rdy_mode = 0;  // 0 manual, 1 always, 2 pattern 1,0,0, 3 random
    int           pat = 0;

    vec_elem_serializer #(.EW(EW), .NELEM(NELEM)) dut (
        .clk(clk), .reset(reset),
        .recv_msg(recv_msg), .recv_vl(recv_vl), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_msg(send_msg), .send_idx(send_idx), .send_last(send_last),
        .send_val(send_val), .send_rdy(send_rdy)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready generator
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: send_rdy = 1'b1;
            2: begin send_rdy = (pat == 0); pat = (pat + 1) % 3; end
            3: send_rdy = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops the expected queue on every element transfer
    logic          stall_prev = 1'b0;
    logic          mid_word = 1'b0;
    logic [W-1:0]  p_out;
    always @(negedge clk) begin
        logic [W-1:0] got;
        got = {send_msg, send_idx, send_last};
        if (reset) begin
            stall_prev = 1'b0;
            mid_word   = 1'b0;
        end else begin
            if (stall_prev) check("stall_hold", {send_val, got}, {1'b1, p_out});
            if (mid_word) check("val_held", 32'(send_val), 32'd1);
            if (send_val) check("recv_rdy_busy", 32'(recv_rdy), 32'(send_rdy && send_last));
            else          check("recv_rdy_idle", 32'(recv_rdy), 32'd1);
            if (send_val && send_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    check("beat", 32'(got), 32'(exp_q.pop_front()));
                end
                beats++;
                beat_cyc.push_back(cyc);
            end
            stall_prev = send_val && !send_rdy;
            mid_word   = send_val && !(send_rdy && send_last);
            p_out      = got;
        end
    end

    // Driver: offer one word, push its expected elements when accepted
    task automatic put_word(input logic [31:0] msg, input int vl);
        bit done = 0;
        int eff;
        recv_msg = msg;
        recv_vl  = VLW'(vl);
        recv_val = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (recv_rdy && !reset) begin
                eff = (vl > NELEM) ? NELEM : vl;
                for (int i = 0; i < eff; i++) begin
                    elem_t m;
                    m = elem_t'(msg >> (i * EW));
                    exp_q.push_back({m, IW'(i), (i == eff - 1)});
                end
                done = 1;
            end
            @(posedge clk); #1;
        end
        recv_val = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        beats = 0;
        beat_cyc.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_send_val", 32'(send_val), 32'd0);
        check("rst_send_msg", 32'(send_msg), 32'd0);
        check("rst_send_idx", 32'(send_idx), 32'd0);
        check("rst_send_last", 32'(send_last), 32'd0);
        check("rst_recv_rdy", 32'(recv_rdy), 32'd1);

        // Single full word, downstream always ready
        rdy_mode = 1;
        start_test();
        put_word(32'h4433_2211, 4);
        drain();
        check("t1_beats", 32'(beats), 32'd4);

        // Two words back-to-back, no bubble
        start_test();
        put_word(32'h4433_2211, 4);
        put_word(32'hDDCC_BBAA, 2);
        drain();
        check("t2_beats", 32'(beats), 32'd6);
        if (beat_cyc.size() == 6) check("t2_no_bubble", 32'(beat_cyc[5] - beat_cyc[0]), 32'd5);

        // Zero-length word dropped, then a one-element word
        start_test();
        put_word(32'hFFFF_FFFF, 0);
        put_word(32'h0000_00EE, 1);
        drain();
        check("t3_beats", 32'(beats), 32'd1);

        // Clamped length with stalls
        rdy_mode = 2;
        pat = 0;
        start_test();
        put_word(32'h8765_4321, 7);
        drain();
        check("t4_beats", 32'(beats), 32'd4);

        // Reset in the middle of a word
        rdy_mode = 0;
        send_rdy = 1'b0;
        put_word(32'h5566_7788, 4);
        send_rdy = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("t5_idx_before_rst", 32'(send_idx), 32'd2);
        send_rdy = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_val_after_rst", 32'(send_val), 32'd0);
        check("t5_rdy_after_rst", 32'(recv_rdy), 32'd1);
        rdy_mode = 1;
        start_test();
        put_word(32'h0000_AB00, 2);
        drain();
        check("t5_beats", 32'(beats), 32'd2);

        // Random lengths, data, gaps and downstream readiness
        rdy_mode = 3;
        start_test();
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            put_word($urandom, $urandom_range(0, NELEM + 2));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
